// File: rtl/bram_stream_fifo_pkg.sv
// Shared constants for the BRAM-backed stream FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package bram_stream_fifo_pkg;

  // Output skid entries; two are enough to absorb the BRAM's one-cycle read latency
  // at one beat per cycle.
  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/dual_port_bram.sv
// Dual-port block RAM, one clock per port, registered read data on both ports.
// Latency: read data valid one cycle after en; writes commit at the clock edge.
// Backpressure: none; the caller sequences accesses.
//
// Ports:
//   a_clk, a_en, a_we (byte enables), a_addr, a_wrdata -> write port; a_rddata is the
//   registered read-before-write value at a_addr.
//   b_clk, b_en, b_addr -> read port; b_rddata is registered.
//   b_we / b_wrdata exist for pin compatibility only: port B is read-only here and
//   users must tie b_we to zero.
module dual_port_bram #(
  parameter int    ADDR_WIDTH      = 9,
  parameter int    DATA_WIDTH      = 64,
  parameter string DEFAULT_CONTENT = ""
) (
  input  logic                    a_clk,
  input  logic                    a_en,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wrdata,
  output logic [DATA_WIDTH-1:0]   a_rddata,
  input  logic                    b_clk,
  input  logic                    b_en,
  input  logic [DATA_WIDTH/8-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wrdata,
  output logic [DATA_WIDTH-1:0]   b_rddata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BE_W  = DATA_WIDTH / 8;

  // Contents are never preloaded in this build; the name is kept for instance compatibility.
  localparam string content_file_unused = DEFAULT_CONTENT;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port B is read-only; its write pins are folded into an unused signal.
  logic b_wr_unused;
  assign b_wr_unused = ^{b_we, b_wrdata};

  always_ff @(posedge a_clk) begin
    if (a_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (a_we[i]) begin
          mem[a_addr][i*8 +: 8] <= a_wrdata[i*8 +: 8];
        end
      end
      a_rddata <= mem[a_addr];
    end
  end

  always_ff @(posedge b_clk) begin
    if (b_en) begin
      b_rddata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/bram_stream_fifo.sv
// Valid/ready stream FIFO on one dual-port BRAM with a 2-entry FWFT output skid.
// Latency: a beat written into an empty FIFO at edge k is presented after edge k+2.
// Backpressure: w_ready drops when occupancy reaches DEPTH; it depends only on registered state.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   w_valid/w_ready/w_data   write stream
//   r_valid/r_ready/r_data   read stream; r_data is registered and held until popped
//   count                    total occupancy, 0..DEPTH
module bram_stream_fifo
  import bram_stream_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                DEPTH      = 2 ** ADDR_WIDTH;
  localparam int                BE_W       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [2:0]        SKID_LIMIT = 3'(SKID_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count;   // committed beats still in the BRAM
  logic                  inflight;    // a BRAM read was issued last cycle
  logic [1:0]            skid_count;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [DATA_WIDTH-1:0] skid_tail;
  logic [DATA_WIDTH-1:0] b_rddata;
  logic [DATA_WIDTH-1:0] bram_a_rddata_unused;

  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [2:0] skid_demand;

  assign count   = mem_count + (ADDR_WIDTH + 1)'(inflight) + (ADDR_WIDTH + 1)'(skid_count);
  assign w_ready = !rst && (count != FULL_COUNT);
  assign r_valid = (skid_count != 2'd0);
  assign r_data  = skid_head;

  assign push = w_valid && w_ready;
  assign pop  = r_valid && r_ready;

  // Skid slots that will be claimed once this cycle's pop and last cycle's read settle.
  // pop implies skid_count >= 1, so this cannot underflow.
  assign skid_demand = {2'b00, inflight} + {1'b0, skid_count} - {2'b00, pop};
  // mem_count only covers committed writes, so a read never targets the address
  // being written in the same cycle.
  assign rd_issue    = (mem_count != '0) && (skid_demand < SKID_LIMIT);

  dual_port_bram #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .DEFAULT_CONTENT ("")
  ) u_bram (
    .a_clk    (clk),
    .a_en     (push),
    .a_we     ({BE_W{1'b1}}),
    .a_addr   (wr_ptr),
    .a_wrdata (w_data),
    .a_rddata (bram_a_rddata_unused),
    .b_clk    (clk),
    .b_en     (rd_issue),
    .b_we     ({BE_W{1'b0}}),
    .b_addr   (rd_ptr),
    .b_wrdata ({DATA_WIDTH{1'b0}}),
    .b_rddata (b_rddata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, rd_issue})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
    end
  end

  // Ordered two-entry skid: head is what the consumer sees, tail queues behind it.
  // On an empty pop the head keeps its old value so r_data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_count <= 2'd0;
      skid_head  <= '0;
      skid_tail  <= '0;
    end else begin
      case ({pop, inflight})
        2'b11: begin
          if (skid_count == 2'd2) begin
            skid_head <= skid_tail;
            skid_tail <= b_rddata;
          end else begin
            skid_head <= b_rddata;
          end
        end
        2'b10: begin
          if (skid_count == 2'd2) begin
            skid_head <= skid_tail;
          end
          skid_count <= skid_count - 2'd1;
        end
        2'b01: begin
          if (skid_count == 2'd0) begin
            skid_head <= b_rddata;
          end else begin
            skid_tail <= b_rddata;
          end
          skid_count <= skid_count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
